// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the chunked serial borrow subtractor.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Width of the chunk counter; a single-chunk build still needs one bit.
    function automatic int cnt_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// One CHUNK-bit slice of the borrow chain, evaluated at CHUNK+1 bits so the
// borrow out is simply the MSB of the widened difference.
module sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bin,
    output logic [CHUNK-1:0] d,
    output logic             bout
);

    logic [CHUNK:0] full;

    // Widened subtract; a wrap below zero sets the extra MSB, which is the borrow.
    always_comb begin
        full = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
        d    = full[CHUNK-1:0];
        bout = full[CHUNK];
    end

endmodule

// File: rtl/sub_borrow_serial.sv
// Multi-cycle unsigned subtractor: diff = in0 - in1 - borrow_in, computed
// CHUNK bits per cycle from the LSB chunk up, with a valid/ready interface on
// both sides. One shared sub_chunk is muxed across slices by the chunk counter.
module sub_borrow_serial
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("sub_borrow_serial: WIDTH must be a positive multiple of CHUNK");
    end

    sub_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             bor;

    logic             accept;
    logic             step;
    logic             last_step;

    logic [CHUNK-1:0] a_slice [NCHUNK];
    logic [CHUNK-1:0] b_slice [NCHUNK];
    logic [CHUNK-1:0] a_k;
    logic [CHUNK-1:0] b_k;
    logic [CHUNK-1:0] d_k;
    logic             bout_k;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign step      = (state == CALC);
    assign last_step = step && (cnt == LAST);

    assign a_k = a_slice[cnt];
    assign b_k = b_slice[cnt];

    sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_k),
        .b    (b_k),
        .bin  (bor),
        .d    (d_k),
        .bout (bout_k)
    );

    for (genvar k = 0; k < NCHUNK; k++) begin : g_slice
        logic [CHUNK-1:0] q;

        assign a_slice[k]             = a_reg[k*CHUNK +: CHUNK];
        assign b_slice[k]             = b_reg[k*CHUNK +: CHUNK];
        assign diff[k*CHUNK +: CHUNK] = q;

        // Each diff slice loads only in the CALC cycle that owns it and holds otherwise.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q <= '0;
            end else if (step && (cnt == CW'(k))) begin
                q <= d_k;
            end
        end
    end

    // Sequencer: IDLE -> CALC for NCHUNK cycles -> DONE until the consumer takes the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (last_step) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operands are captured at acceptance so the producer may move on immediately;
    // the running borrow starts from borrow_in and then follows the chunk chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            bor   <= 1'b0;
        end else if (accept) begin
            a_reg <= in0;
            b_reg <= in1;
            bor   <= borrow_in;
        end else if (step) begin
            bor <= bout_k;
        end
    end

    // The final chunk's borrow is the borrow out of the whole word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            borrow_out <= 1'b0;
        end else if (last_step) begin
            borrow_out <= bout_k;
        end
    end

endmodule

// File: tb/tb_sub_borrow_serial.sv
// Bench for sub_borrow_serial: directed vectors, backpressure, reset abort and
// back-to-back traffic on a CHUNK=4 instance, plus randomized scoreboarded
// traffic on CHUNK = 1, 4, 8, 16 instances running alongside.
module tb_sub_borrow_serial;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int NRAND  = 1500;

    typedef struct {
        logic [15:0] in0;
        logic [15:0] in1;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks  = 0;
    int passed_checks = 0;
    bit rand_done [4];

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow_out;
    logic [16:0] exp_q [$];

    sub_borrow_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in0        (in0),
        .in1        (in1),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c,
                                 input logic [16:0] expected);
        int waits;
        in0       = a;
        in1       = b;
        borrow_in = c;
        in_valid  = 1'b1;
        waits     = 0;
        while (in_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(expected);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in0       = 16'($urandom);
        in1       = 16'($urandom);
        borrow_in = 1'($urandom_range(0, 1));
    endtask

    // Counts negedges since the accepting edge until out_valid is seen.
    task automatic waitResult(output int cycles);
        cycles = 1;
        while (out_valid !== 1'b1 && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic popCompare(input string name);
        if (exp_q.size() == 0) begin
            checkOutput({name, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            checkOutput(name, {15'd0, borrow_out, diff}, {15'd0, exp_q.pop_front()});
        end
    endtask

    initial begin : main
        vec_t        vecs [11];
        int          cyc;
        int          acc;
        int          res;
        int          last_acc;
        int          waits;
        logic        seen_valid;
        logic [15:0] b2b_a [3];
        logic [15:0] b2b_b [3];
        logic        b2b_c [3];
        logic [16:0] b2b_e [3];

        vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
        vecs[4]  = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
        vecs[6]  = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0};
        vecs[7]  = '{16'h00F0, 16'h0F00, 1'b0, 16'hF1F0, 1'b1};
        vecs[8]  = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0};
        vecs[9]  = '{16'h1000, 16'h1000, 1'b0, 16'h0000, 1'b0};
        vecs[10] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0};

        b2b_a[0] = 16'h0003; b2b_b[0] = 16'h0001; b2b_c[0] = 1'b0; b2b_e[0] = {1'b0, 16'h0002};
        b2b_a[1] = 16'h0001; b2b_b[1] = 16'h0003; b2b_c[1] = 1'b0; b2b_e[1] = {1'b1, 16'hFFFE};
        b2b_a[2] = 16'hF00F; b2b_b[2] = 16'h0FF0; b2b_c[2] = 1'b1; b2b_e[2] = {1'b0, 16'hE01E};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in0       = 16'hDEAD;
        in1       = 16'hBEEF;
        borrow_in = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", {13'd0, in_ready, out_valid, borrow_out, diff},
                    {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].in0, vecs[i].in1, vecs[i].bin, {vecs[i].bout, vecs[i].diff});
            checkOutput($sformatf("busy_in_ready_%0d", i), {31'd0, in_ready}, 32'd0);
            waitResult(cyc);
            checkOutput($sformatf("latency_%0d", i), cyc, NCHUNK + 1);
            popCompare($sformatf("vec_%0d", i));
            @(negedge clk);
            checkOutput($sformatf("idle_after_%0d", i), {30'd0, in_ready, out_valid}, 32'b10);
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(16'h5A5A, 16'h1234, 1'b0, {1'b0, 16'h4826});
        waitResult(cyc);
        in0       = 16'h0100;
        in1       = 16'h0200;
        borrow_in = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("hold_%0d", k), {13'd0, out_valid, in_ready, borrow_out, diff},
                        {13'd0, 1'b1, 1'b0, 1'b0, 16'h4826});
            @(negedge clk);
        end
        popCompare("held_result");
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("accept_after_handshake", {30'd0, in_ready, out_valid}, 32'b10);
        exp_q.push_back({1'b1, 16'hFEFF});
        @(negedge clk);
        in_valid = 1'b0;
        waitResult(cyc);
        checkOutput("latency_after_hold", cyc, NCHUNK + 1);
        popCompare("queued_result");
        @(negedge clk);

        $display("[TB] reset during CALC");
        applyStimulus(16'h7777, 16'h1111, 1'b0, {1'b0, 16'h6666});
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_abort_state", {13'd0, in_ready, out_valid, borrow_out, diff},
                    {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        void'(exp_q.pop_back());
        rst_n      = 1'b1;
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checkOutput("no_aborted_result", {31'd0, seen_valid}, 32'd0);
        applyStimulus(16'h7777, 16'h1111, 1'b1, {1'b0, 16'h6665});
        waitResult(cyc);
        popCompare("after_reset_result");
        @(negedge clk);

        $display("[TB] back-to-back");
        out_ready = 1'b1;
        acc       = 0;
        res       = 0;
        cyc       = 0;
        last_acc  = 0;
        in0       = b2b_a[0];
        in1       = b2b_b[0];
        borrow_in = b2b_c[0];
        in_valid  = 1'b1;
        while ((acc < 3 || res < 3) && cyc < 100) begin
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(b2b_e[acc]);
                if (acc > 0) checkOutput($sformatf("b2b_interval_%0d", acc), cyc - last_acc, 6);
                last_acc = cyc;
                acc++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                popCompare($sformatf("b2b_result_%0d", res));
                res++;
            end
            @(negedge clk);
            cyc++;
            if (acc < 3) begin
                in0       = b2b_a[acc];
                in1       = b2b_b[acc];
                borrow_in = b2b_c[acc];
            end else begin
                in_valid = 1'b0;
            end
        end
        if (res < 3) checkOutput("b2b_timeout", res, 3);

        waits = 0;
        while (!(rand_done[0] && rand_done[1] && rand_done[2] && rand_done[3]) && waits < 80000) begin
            @(negedge clk);
            waits++;
        end
        if (!(rand_done[0] && rand_done[1] && rand_done[2] && rand_done[3])) begin
            checkOutput("rand_finish_timeout", 32'd0, 32'd1);
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int RC = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 16;

        logic        r_rst_n;
        logic        r_in_valid;
        logic        r_in_ready;
        logic [15:0] r_in0;
        logic [15:0] r_in1;
        logic        r_bin;
        logic        r_out_valid;
        logic        r_out_ready;
        logic [15:0] r_diff;
        logic        r_bout;
        logic [16:0] r_q [$];

        sub_borrow_serial #(.WIDTH(16), .CHUNK(RC)) u_dut (
            .clk        (clk),
            .rst_n      (r_rst_n),
            .in_valid   (r_in_valid),
            .in_ready   (r_in_ready),
            .in0        (r_in0),
            .in1        (r_in1),
            .borrow_in  (r_bin),
            .out_valid  (r_out_valid),
            .out_ready  (r_out_ready),
            .diff       (r_diff),
            .borrow_out (r_bout)
        );

        initial begin : driver
            int waits;
            r_rst_n    = 1'b0;
            r_in_valid = 1'b0;
            r_in0      = 16'h0000;
            r_in1      = 16'h0000;
            r_bin      = 1'b0;
            repeat (3) @(negedge clk);
            r_rst_n = 1'b1;
            for (int i = 0; i < NRAND; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                r_in0      = pick_operand();
                r_in1      = pick_operand();
                r_bin      = 1'($urandom_range(0, 1));
                r_in_valid = 1'b1;
                waits      = 0;
                while (r_in_ready !== 1'b1 && waits < 200) begin
                    @(negedge clk);
                    waits++;
                end
                if (r_in_ready !== 1'b1) begin
                    checkOutput($sformatf("rand_c%0d_accept_timeout", RC), 32'd0, 32'd1);
                    break;
                end
                r_q.push_back({1'b0, r_in0} - {1'b0, r_in1} - {16'd0, r_bin});
                @(negedge clk);
                r_in_valid = 1'b0;
                r_in0      = 16'($urandom);
                r_in1      = 16'($urandom);
                r_bin      = 1'($urandom_range(0, 1));
            end
        end

        initial begin : monitor
            int seen;
            int cyc;
            seen        = 0;
            cyc         = 0;
            r_out_ready = 1'b0;
            while (seen < NRAND && cyc < NRAND * 40) begin
                @(negedge clk);
                cyc++;
                r_out_ready = ($urandom_range(0, 3) != 0);
                if (r_out_valid === 1'b1 && r_out_ready) begin
                    if (r_q.size() == 0) begin
                        checkOutput($sformatf("rand_c%0d_unexpected", RC), 32'd1, 32'd0);
                    end else begin
                        checkOutput($sformatf("rand_c%0d_op%0d", RC, seen),
                                    {15'd0, r_bout, r_diff}, {15'd0, r_q.pop_front()});
                    end
                    seen++;
                end
            end
            if (seen < NRAND) checkOutput($sformatf("rand_c%0d_timeout", RC), seen, NRAND);
            rand_done[g] = 1'b1;
        end
    end

endmodule
